// File: rtl/note_lane_shifter_if.sv
// note_lane_shifter_if: pattern write, playback control and display bus of the note lane shifter
interface note_lane_shifter_if #(
    parameter int LANES = 3,
    parameter int SONG_LEN = 100,
    parameter int WINDOW = 10,
    localparam int ADDR_W = $clog2(SONG_LEN)
);
    logic wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [LANES-1:0] wr_data;
    logic start;
    logic stop;
    logic step;
    logic loop_en;
    logic [LANES*WINDOW-1:0] window;
    logic [LANES-1:0] judge;
    logic [ADDR_W-1:0] pos;
    logic busy;
    logic done;
    logic wrap;
    modport master (
        output wr_en, wr_addr, wr_data, start, stop, step, loop_en,
        input  window, judge, pos, busy, done, wrap
    );
    modport slave (
        input  wr_en, wr_addr, wr_data, start, stop, step, loop_en,
        output window, judge, pos, busy, done, wrap
    );
endinterface

// File: rtl/note_lane_shifter.sv
// note_lane_shifter: scrolls a stored multi-lane song through per-lane display windows
// Define NOTE_SHIFTER_LOOP_EN to let loop_en wrap the song instead of draining it.
module note_lane_shifter #(
    parameter int LANES = 3,
    parameter int SONG_LEN = 100,
    parameter int WINDOW = 10,
    localparam int ADDR_W = $clog2(SONG_LEN)
) (
    input logic clk,
    input logic resetn,
    note_lane_shifter_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0, PLAY = 2'd1, DRAIN = 2'd2, DONE = 2'd3;
    localparam int DW = $clog2(WINDOW + 1);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(SONG_LEN - 1);
    localparam logic [DW-1:0] DLAST = DW'(WINDOW - 1);
    logic [1:0] state;
    logic [LANES-1:0] mem [SONG_LEN];
    logic [LANES*WINDOW-1:0] win, shifted;
    logic [LANES-1:0] feed;
    logic [ADDR_W-1:0] pos;
    logic [DW-1:0] drain_cnt;
    logic wrap, idle_like, abort, feed_last, loop_hit;
    assign idle_like = state == IDLE || state == DONE;
    assign abort = bus.stop && !idle_like;
    assign feed = state == PLAY ? mem[pos] : '0;
    assign feed_last = pos == LAST;
`ifdef NOTE_SHIFTER_LOOP_EN
    assign loop_hit = feed_last && bus.loop_en;
`else
    logic unused_loop_en;
    assign unused_loop_en = bus.loop_en;
    assign loop_hit = 1'b0;
`endif
    genvar i;
    generate
        for (i = 0; i < LANES; i++) begin : g_lane
            assign shifted[i*WINDOW +: WINDOW] = {feed[i], win[i*WINDOW+1 +: WINDOW-1]};
            assign bus.judge[i] = win[i*WINDOW];
        end
    endgenerate
    // Pattern memory has no reset so a loaded song survives resetn.
    always_ff @(posedge clk)
        if (bus.wr_en && idle_like && {1'b0, bus.wr_addr} < (ADDR_W+1)'(SONG_LEN))
            mem[bus.wr_addr] <= bus.wr_data;
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
            state <= IDLE;
            win <= '0;
            pos <= '0;
            drain_cnt <= '0;
            wrap <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (abort || bus.start) begin
                state <= abort ? IDLE : PLAY;
                win <= '0;
                pos <= '0;
                drain_cnt <= '0;
            end else if (bus.step && state == PLAY) begin
                win <= shifted;
                pos <= feed_last ? '0 : pos + 1'b1;
                wrap <= loop_hit;
                state <= feed_last && !loop_hit ? DRAIN : PLAY;
                drain_cnt <= '0;
            end else if (bus.step && state == DRAIN) begin
                win <= shifted;
                drain_cnt <= drain_cnt + 1'b1;
                state <= drain_cnt == DLAST ? DONE : DRAIN;
            end
        end
    assign bus.window = win;
    assign bus.pos = pos;
    assign bus.busy = state == PLAY || state == DRAIN;
    assign bus.done = state == DONE;
    assign bus.wrap = wrap;
endmodule
